// File: rtl/seg7_pkg.sv
// Shared constants for the stopwatch 7-segment display back-end.
package seg7_pkg;

    // Active-low segment codes, bit order gfedcba.
    localparam logic [6:0] SEG_CODE_0 = 7'b1000000;
    localparam logic [6:0] SEG_CODE_1 = 7'b1111001;
    localparam logic [6:0] SEG_CODE_2 = 7'b0100100;
    localparam logic [6:0] SEG_CODE_3 = 7'b0110000;
    localparam logic [6:0] SEG_CODE_4 = 7'b0011001;
    localparam logic [6:0] SEG_CODE_5 = 7'b0010010;
    localparam logic [6:0] SEG_CODE_6 = 7'b0000010;
    localparam logic [6:0] SEG_CODE_7 = 7'b1111000;
    localparam logic [6:0] SEG_CODE_8 = 7'b0000000;
    localparam logic [6:0] SEG_CODE_9 = 7'b0010000;
    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam logic [3:0] AN_OFF     = 4'hF;

    // Default dividers for a 100 MHz system clock: 1 ms per digit, 250 ms blink half-period.
    localparam int unsigned SCAN_DIV_100M  = 100000;
    localparam int unsigned BLINK_DIV_100M = 25000000;

endpackage

// File: rtl/seg7_decoder.sv
// BCD nibble to active-low 7-segment code; values 10..15 blank the digit.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Pure lookup of the segment pattern for one digit.
    always_comb begin
        seg_o = SEG_OFF;
        case (bcd_i)
            4'd0:    seg_o = SEG_CODE_0;
            4'd1:    seg_o = SEG_CODE_1;
            4'd2:    seg_o = SEG_CODE_2;
            4'd3:    seg_o = SEG_CODE_3;
            4'd4:    seg_o = SEG_CODE_4;
            4'd5:    seg_o = SEG_CODE_5;
            4'd6:    seg_o = SEG_CODE_6;
            4'd7:    seg_o = SEG_CODE_7;
            4'd8:    seg_o = SEG_CODE_8;
            4'd9:    seg_o = SEG_CODE_9;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexes a 4-digit BCD value onto a common-anode 7-segment display,
// with whole-display blinking while blink_en is high.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = SCAN_DIV_100M,
    parameter int unsigned BLINK_DIV = BLINK_DIV_100M
) (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic [15:0] bcd_in,
    input  logic        blink_en,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int unsigned ScanW  = $clog2(SCAN_DIV);
    localparam int unsigned BlinkW = $clog2(BLINK_DIV);
    localparam logic [ScanW-1:0]  ScanLast  = ScanW'(SCAN_DIV - 1);
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);

    logic [ScanW-1:0]  scan_cnt_q, scan_cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              blink_vis_q, blink_vis_d;
    logic [6:0]        seg_q, seg_d;
    logic [3:0]        an_q, an_d;
    logic [3:0]        nibble;
    logic [6:0]        nibble_seg;
    logic              visible;

    // Digit-slot timer and active digit index.
    always_comb begin
        scan_cnt_d = scan_cnt_q + ScanW'(1);
        idx_d      = idx_q;
        if (scan_cnt_q == ScanLast) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 2'd1;
        end
    end

    // Blink phase timer; held cleared and visible while blinking is disabled.
    always_comb begin
        blink_cnt_d = '0;
        blink_vis_d = 1'b1;
        if (blink_en) begin
            blink_vis_d = blink_vis_q;
            if (blink_cnt_q == BlinkLast) begin
                blink_cnt_d = '0;
                blink_vis_d = ~blink_vis_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BlinkW'(1);
            end
        end
    end

    // Select the live (unlatched) nibble for the active digit.
    always_comb begin
        nibble = bcd_in[3:0];
        case (idx_q)
            2'd0: nibble = bcd_in[3:0];
            2'd1: nibble = bcd_in[7:4];
            2'd2: nibble = bcd_in[11:8];
            2'd3: nibble = bcd_in[15:12];
            default: nibble = bcd_in[3:0];
        endcase
    end

    seg7_decoder u_decoder (
        .bcd_i (nibble),
        .seg_o (nibble_seg)
    );

    // Dropping blink_en restores the display on the very next edge, even mid off-phase.
    assign visible = blink_vis_q | ~blink_en;

    // Next output values; an and seg change together so no digit shows a stale pattern.
    always_comb begin
        seg_d = nibble_seg;
        an_d  = visible ? ~(4'b0001 << idx_q) : AN_OFF;
    end

    // State and registered outputs.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_cnt_q  <= '0;
            idx_q       <= 2'd0;
            blink_cnt_q <= '0;
            blink_vis_q <= 1'b1;
            seg_q       <= SEG_OFF;
            an_q        <= AN_OFF;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_vis_q <= blink_vis_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with a cycle-level reference model.
module tb_seg7_scan_driver;

    localparam int unsigned SCAN_DIV  = 4;
    localparam int unsigned BLINK_DIV = 16;

    logic        sys_clk = 1'b0;
    logic        reset_n;
    logic [15:0] bcd_in;
    logic        blink_en;
    logic [6:0]  seg;
    logic [3:0]  an;

    int n_tests = 0;
    int n_fail  = 0;

    seg7_scan_driver #(
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .sys_clk  (sys_clk),
        .reset_n  (reset_n),
        .bcd_in   (bcd_in),
        .blink_en (blink_en),
        .seg      (seg),
        .an       (an)
    );

    always #5 sys_clk = ~sys_clk;

    // Digit table straight from the display datasheet, gfedcba active-low.
    logic [6:0] digit_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
    };

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_k = edges since reset release, m_e = consecutive edges with blink_en high.
    int         m_k = 0;
    int         m_e = 0;
    int         m_idx;
    bit         m_vis;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;

    // Predict outputs at every edge from inputs seen at that edge, then compare.
    always @(posedge sys_clk) begin
        if (!reset_n) begin
            m_k     = 0;
            m_e     = 0;
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
        end else begin
            m_idx   = (m_k / SCAN_DIV) % 4;
            m_vis   = !blink_en || (((m_e / BLINK_DIV) % 2) == 0);
            exp_an  = m_vis ? ~(4'(1) << m_idx) : 4'hF;
            exp_seg = digit_tbl[(bcd_in >> (m_idx * 4)) & 16'hF];
            m_k     = m_k + 1;
            m_e     = blink_en ? m_e + 1 : 0;
        end
        #1;
        check("model_an", {3'b0, an}, {3'b0, exp_an});
        check("model_seg", seg, exp_seg);
    end

    logic [3:0] an_lit   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] seg_5999 [4] = '{7'b0010000, 7'b0010000, 7'b0010000, 7'b0010010};
    logic [6:0] seg_a3f0 [4] = '{7'b1000000, 7'b1111111, 7'b0110000, 7'b1111111};

    task automatic align16();
        int guard = 0;
        @(negedge sys_clk);
        while ((m_k % 16) != 0 && guard < 32) begin
            @(negedge sys_clk);
            guard++;
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        bcd_in   = 16'h5999;
        blink_en = 1'b0;

        // Held in reset: display dark.
        for (int i = 0; i < 20; i++) begin
            #10;
            check("reset_an", {3'b0, an}, {3'b0, 4'hF});
            check("reset_seg", seg, 7'h7F);
        end

        // Release and follow one full scan with 5999.
        @(negedge sys_clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge sys_clk);
            #2;
            check("scan5999_an", {3'b0, an}, {3'b0, an_lit[(k - 1) / 4]});
            check("scan5999_seg", seg, seg_5999[(k - 1) / 4]);
        end

        // Mid-slot value change on digit 0 shows one cycle later.
        @(negedge sys_clk);
        bcd_in = 16'h0000;
        @(posedge sys_clk);
        #2;
        check("chg_seg0", seg, 7'b1000000);
        check("chg_an0", {3'b0, an}, {3'b0, 4'b1110});
        @(negedge sys_clk);
        bcd_in = 16'h0001;
        @(posedge sys_clk);
        #2;
        check("chg_seg1", seg, 7'b1111001);
        check("chg_an1", {3'b0, an}, {3'b0, 4'b1110});

        // Invalid BCD nibbles blank their digit while the anode stays enabled.
        align16();
        bcd_in = 16'hA3F0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge sys_clk);
            #2;
            check("a3f0_an", {3'b0, an}, {3'b0, an_lit[(k - 1) / 4]});
            check("a3f0_seg", seg, seg_a3f0[(k - 1) / 4]);
        end

        // Random values and blink toggling, checked by the model.
        for (int i = 0; i < 800; i++) begin
            @(negedge sys_clk);
            if ($urandom_range(7) == 0) bcd_in = 16'($urandom);
            if ($urandom_range(99) == 0) blink_en = ~blink_en;
        end

        // Blink: 16 visible, 16 dark, repeat; drop blink_en in a dark phase.
        @(negedge sys_clk);
        blink_en = 1'b0;
        bcd_in   = 16'h5999;
        align16();
        blink_en = 1'b1;
        for (int k = 1; k <= 52; k++) begin
            @(posedge sys_clk);
            #2;
            if (((k - 1) / 16) % 2 == 1)
                check("blink_dark_an", {3'b0, an}, {3'b0, 4'hF});
            else
                check("blink_vis_an", {3'b0, an}, {3'b0, an_lit[((k - 1) / 4) % 4]});
        end
        @(negedge sys_clk);
        blink_en = 1'b0;
        @(posedge sys_clk);
        #2;
        check("blink_drop_an", {3'b0, an}, {3'b0, an_lit[1]});

        // Async reset mid dark phase while digit 2 is active.
        align16();
        blink_en = 1'b1;
        repeat (26) @(posedge sys_clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_an", {3'b0, an}, {3'b0, 4'hF});
        check("async_rst_seg", seg, 7'h7F);
        @(posedge sys_clk);
        @(negedge sys_clk);
        reset_n = 1'b1;
        @(posedge sys_clk);
        #2;
        check("restart_an", {3'b0, an}, {3'b0, 4'b1110});
        check("restart_seg", seg, 7'b0010000);
        repeat (40) @(posedge sys_clk);

        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
